// File: rtl/pc_gen.sv
// Program counter generator: selects the next PC among sequential, branch,
// jump, register-jump, exception and exception-return targets. A redirect
// that arrives while the front end is stalled is parked in a pending register
// and applied on the first unstalled edge. Exceptions always win, even under
// stall, and drop any parked redirect.
module pc_gen #(
    parameter int              AW         = 32,
    parameter logic [AW-1:0]   RESET_PC   = AW'(32'h0000_3000),
    parameter logic [AW-1:0]   EXC_VECTOR = AW'(32'h0000_4180)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          stall,
    input  logic [2:0]    npc_op,
    input  logic [25:0]   imm,
    input  logic [AW-1:0] rs_data,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] epc,
    output logic          pend_valid,
    output logic          redirect,
    output logic          addr_err
);

    localparam logic [2:0] OP_PLUS4  = 3'b000;
    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_JR     = 3'b011;
    localparam logic [2:0] OP_EXC    = 3'b100;
    localparam logic [2:0] OP_ERET   = 3'b101;

    // Branch displacement: word offset scaled to bytes, sign-extended to AW.
    function automatic logic signed [AW-1:0] br_offset(input logic [15:0] off16);
        logic signed [AW-1:0] off_s;
        off_s = {{(AW-18){off16[15]}}, off16, 2'b00};
        return off_s;
    endfunction

    logic [AW-1:0]        pc_p1;
    logic [AW-1:0]        epc_p1;
    logic [AW-1:0]        pend_tgt_p1;
    logic                 pend_vld_p1;
    logic                 redirect_p1;
    logic                 addr_err_p1;

    logic [AW-1:0]        pcplus4_p0;
    logic signed [AW-1:0] br_tgt_p0;
    logic [AW-1:0]        jmp_tgt_p0;
    logic [AW-1:0]        tgt_p0;
    logic                 is_redir_p0;
    logic                 jr_misalign_p0;
    logic                 take_exc_p0;

    assign pcplus4_p0 = pc_p1 + AW'(4);
    assign br_tgt_p0  = $signed(pcplus4_p0) + br_offset(imm[15:0]);

    // Jump keeps the region bits above bit 27 from the sequential PC.
    generate
        if (AW > 28) begin : g_jmp_region
            assign jmp_tgt_p0 = {pcplus4_p0[AW-1:28], imm, 2'b00};
        end else begin : g_jmp_flat
            assign jmp_tgt_p0 = {imm, 2'b00};
        end
    endgenerate

    // ---- stage p0: decode the requested next-PC target ----
    // Target select; reserved encodings fall back to sequential flow.
    always_comb begin
        tgt_p0         = pcplus4_p0;
        is_redir_p0    = 1'b0;
        jr_misalign_p0 = (npc_op == OP_JR) && (rs_data[1:0] != 2'b00);
        take_exc_p0    = (npc_op == OP_EXC) || jr_misalign_p0;
        case (npc_op)
            OP_PLUS4:  begin tgt_p0 = pcplus4_p0;          is_redir_p0 = 1'b0; end
            OP_BRANCH: begin tgt_p0 = $unsigned(br_tgt_p0); is_redir_p0 = 1'b1; end
            OP_JUMP:   begin tgt_p0 = jmp_tgt_p0;          is_redir_p0 = 1'b1; end
            OP_JR:     begin tgt_p0 = rs_data;             is_redir_p0 = 1'b1; end
            OP_EXC:    begin tgt_p0 = EXC_VECTOR;          is_redir_p0 = 1'b1; end
            OP_ERET:   begin tgt_p0 = epc_p1;              is_redir_p0 = 1'b1; end
            default:   begin tgt_p0 = pcplus4_p0;          is_redir_p0 = 1'b0; end
        endcase
    end

    // ---- stage p1: PC, EPC and pending-redirect state ----
    // Priority: exception, then release of a parked redirect, then the current op.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_p1       <= RESET_PC;
            epc_p1      <= '0;
            pend_tgt_p1 <= '0;
            pend_vld_p1 <= 1'b0;
            redirect_p1 <= 1'b0;
            addr_err_p1 <= 1'b0;
        end else begin
            redirect_p1 <= 1'b0;
            addr_err_p1 <= 1'b0;
            if (take_exc_p0) begin
                pc_p1       <= EXC_VECTOR;
                epc_p1      <= pc_p1;
                pend_vld_p1 <= 1'b0;
                redirect_p1 <= 1'b1;
                addr_err_p1 <= jr_misalign_p0;
            end else if (pend_vld_p1) begin
                if (!stall) begin
                    pc_p1       <= pend_tgt_p1;
                    pend_vld_p1 <= 1'b0;
                    redirect_p1 <= 1'b1;
                end
            end else if (!stall) begin
                pc_p1       <= tgt_p0;
                redirect_p1 <= is_redir_p0;
            end else if (is_redir_p0) begin
                pend_tgt_p1 <= tgt_p0;
                pend_vld_p1 <= 1'b1;
            end
        end
    end

    assign pc         = pc_p1;
    assign epc        = epc_p1;
    assign pend_valid = pend_vld_p1;
    assign redirect   = redirect_p1;
    assign addr_err   = addr_err_p1;

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter AW, default 32, meaning PC/address width; legal range 28..64.
REQ-002 Parameter RESET_PC, default 32'h0000_3000, meaning PC value loaded on reset.
REQ-003 Parameter EXC_VECTOR, default 32'h0000_4180, meaning exception entry address.
REQ-004 clk  input  1  meaning system clock; all state updates on rising edge.
REQ-005 rstn  input  1  meaning reset; asynchronous, active-low.
REQ-006 stall  input  1  meaning hold PC this cycle.
REQ-007 npc_op  input  3  meaning next-PC select: 000 PLUS4, 001 BRANCH, 010 JUMP, 011 JR, 100 EXC, 101 ERET, 110/111 reserved.
REQ-008 imm  input  26  meaning instruction immediate (branch offset in [15:0], jump index in [25:0]).
REQ-009 rs_data  input  AW  meaning register jump target for JR.
REQ-010 pc  output  AW  meaning current PC (registered).
REQ-011 epc  output  AW  meaning saved exception PC (registered).
REQ-012 pend_valid  output  1  meaning a redirect is held awaiting stall release.
REQ-013 redirect  output  1  meaning PC was loaded non-sequentially on the last edge (flush hint).
REQ-014 addr_err  output  1  meaning misaligned JR target trapped on the last edge.

Function
REQ-015 pcplus4 = pc + 4, modulo 2^AW.
REQ-016 BRANCH target = pcplus4 + sign-extended {imm[15:0], 2'b00}, modulo 2^AW (wrap, no flag).
REQ-017 JUMP target = {pcplus4[AW-1:28], imm[25:0], 2'b00}; at AW=28, {imm, 2'b00}.
REQ-018 JR target = rs_data; if rs_data[1:0] != 0, operation becomes EXC with addr_err set for one cycle.
REQ-019 ERET target = epc; reserved ops behave as PLUS4.
REQ-020 EXC (explicit or JR-misaligned): pc <= EXC_VECTOR, epc <= current pc, pend_valid <= 0; executes even when stall=1.
REQ-021 Priority per edge: EXC > pending redirect release > current npc_op.
REQ-022 stall=0, pend_valid=0: pc <= target of npc_op.
REQ-023 stall=1, pend_valid=0, op non-PLUS4 non-EXC: pc held, target captured in pending register, pend_valid <= 1.
REQ-024 stall=1, pend_valid=1: pc and pending target held; npc_op ignored except EXC.
REQ-025 stall=0, pend_valid=1: pc <= pending target, pend_valid <= 0; npc_op that cycle ignored except EXC.
REQ-026 stall=1 with PLUS4: pc held, no state change.
REQ-027 redirect = 1 for exactly one cycle after any edge loading pc with a value other than pcplus4 via BRANCH/JUMP/JR/EXC/ERET/pending release; taken branch to pcplus4 still asserts redirect.
REQ-028 addr_err asserts only with redirect; both deassert next cycle unless re-triggered.
REQ-029 Latency: target visible on pc one edge after the selecting cycle; zero-cycle combinational path from inputs to outputs is forbidden.

Reset
REQ-030 rstn=0 immediately forces pc=RESET_PC, epc=0, pend_valid=0, redirect=0, addr_err=0, pending target=0, regardless of clk.
REQ-031 Reset mid-stall or mid-pending discards the pending redirect; first edge after rstn rises applies normal rules.

Verification
REQ-032 Reset release, op PLUS4 x3 -> pc 0x3000, 0x3004, 0x3008, 0x300C; redirect=0.
REQ-033 pc=0x3010, BRANCH imm[15:0]=0xFFFE -> pc=0x300C, redirect=1 one cycle; pc=0x7FFF_FFFC, BRANCH imm=0x0001 -> pc=0x8000_0004.
REQ-034 pc=0x3000, stall=1 with JUMP imm=0x0000_100 for 2 cycles -> pc stays 0x3000, pend_valid=1; stall=0 -> pc=0x0000_0400, pend_valid=0.
REQ-035 pc=0x3020, JR rs_data=0x0000_3002 -> pc=0x4180, epc=0x3020, addr_err=1, redirect=1; then ERET -> pc=0x3020.
REQ-036 pend_valid=1, stall=1, EXC -> pc=0x4180, pend_valid=0; rstn pulse low while pend_valid=1 -> pc=0x3000 asynchronously, pend_valid=0.
REQ-037 Repeat REQ-032/033 with AW=64, RESET_PC=0x0000_0000_0000_3000; JUMP keeps pc[63:28] from pcplus4.
